// File: rtl/regfile_sb.sv
// Integer register file with two registered read ports, one write port, write-first bypass
// and a pending-write scoreboard that flags source registers still awaiting writeback.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int INIT_IDX = 5,
    parameter int INIT_VAL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_en,
    input  logic [AW-1:0]   rr1,
    input  logic [AW-1:0]   rr2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wr,
    input  logic [XLEN-1:0] wd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    logic [XLEN-1:0]  regs [DEPTH];
    logic [DEPTH-1:0] busy;

    // True for an index that names a writable architectural register (not x0, not past DEPTH).
    function automatic logic writable(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < (AW+1)'(DEPTH));
    endfunction

    function automatic logic [XLEN-1:0] value(input logic [AW-1:0] a);
        if (!writable(a))
            return '0;
        else if (we && (wr == a))
            return wd;
        else
            return regs[a];
    endfunction

    // NOTE: the array is reset element by element because the architectural state after
    // reset is defined (all zero plus one preload); this costs a reset net on every flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= ((INIT_IDX != 0) && (i == INIT_IDX)) ? XLEN'(INIT_VAL) : '0;
        end else if (we && writable(wr)) begin
            regs[wr] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1 <= '0;
            rd2 <= '0;
        end else if (rd_en) begin
            rd1 <= value(rr1);
            rd2 <= value(rr2);
        end
    end

    // NOTE: both updates are non-blocking to the same vector; the later assignment in
    // program order takes effect, which is what makes a same-index issue beat the retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (we && writable(wr))
                busy[wr] <= 1'b0;
            if (iss_valid && writable(iss_rd))
                busy[iss_rd] <= 1'b1;
        end
    end

    // A writeback landing this cycle satisfies the hazard through the bypass.
    always_comb begin
        rs1_busy = writable(rr1) && busy[rr1] && !(we && (wr == rr1));
        rs2_busy = writable(rr2) && busy[rr2] && !(we && (wr == rr2));
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: reset/preload, write/read, x0, bypass,
// read hold, scoreboard set/clear/set-wins, flush priority and asynchronous reset.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rd_en;
    logic [AW-1:0]   rr1, rr2;
    logic [XLEN-1:0] rd1, rd2;
    logic            we;
    logic [AW-1:0]   wr;
    logic [XLEN-1:0] wd;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            flush;
    logic            rs1_busy, rs2_busy;

    int vectors = 0;
    int errors  = 0;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
        .we(we), .wr(wr), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; we = 1'b0; wr = '0; wd = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rr1 = '0; rr2 = '0;
        rst_n = 1'b0;
        #23;
        vectors++;
        if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h want 0", rd1); end
        rst_n = 1'b1;
        #1;
        rd_en = 1'b1; rr1 = 5'd5; rr2 = 5'd3;
        step();
        vectors++;
        if (rd1 !== 32'd4) begin errors++; $display("FAIL preload_rd1 got %h want 4", rd1); end
        vectors++;
        if (rd2 !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h want 0", rd2); end
        vectors++;
        if ({rs1_busy, rs2_busy} !== 2'b00) begin
            errors++; $display("FAIL reset_busy got %b want 00", {rs1_busy, rs2_busy});
        end
    endtask

    task automatic test_write_read();
        idle();
        we = 1'b1; wr = 5'd7; wd = 32'hDEADBEEF;
        step();
        we = 1'b1; wr = 5'd0; wd = 32'h1234;
        rd_en = 1'b1; rr1 = 5'd7; rr2 = 5'd0;
        step();
        vectors++;
        if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_r7 got %h want deadbeef", rd1); end
        vectors++;
        if (rd2 !== 32'h0) begin errors++; $display("FAIL x0_bypass got %h want 0", rd2); end
        idle();
        rd_en = 1'b1; rr1 = 5'd0; rr2 = 5'd7;
        step();
        vectors++;
        if (rd1 !== 32'h0) begin errors++; $display("FAIL x0_stored got %h want 0", rd1); end
        vectors++;
        if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_r7_port2 got %h want deadbeef", rd2); end
    endtask

    task automatic test_bypass();
        idle();
        we = 1'b1; wr = 5'd9; wd = 32'hA5A5A5A5;
        rd_en = 1'b1; rr1 = 5'd9; rr2 = 5'd7;
        step();
        vectors++;
        if (rd1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_rd1 got %h want a5a5a5a5", rd1); end
        rd_en = 1'b0; we = 1'b1; wr = 5'd9; wd = 32'h1;
        step();
        vectors++;
        if (rd1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL hold_rd1 got %h want a5a5a5a5", rd1); end
        vectors++;
        if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_rd2 got %h want deadbeef", rd2); end
        idle();
        rd_en = 1'b1;
        step();
        vectors++;
        if (rd1 !== 32'h1) begin errors++; $display("FAIL rewrite_r9 got %h want 1", rd1); end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd12;
        step();
        idle();
        rr1 = 5'd12; rr2 = 5'd12;
        #1;
        vectors++;
        if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set_rs1 got %b want 1", rs1_busy); end
        vectors++;
        if (rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_set_rs2 got %b want 1", rs2_busy); end
        we = 1'b1; wr = 5'd12; wd = 32'h77;
        #1;
        vectors++;
        if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_wb_comb got %b want 0", rs1_busy); end
        step();
        idle();
        #1;
        vectors++;
        if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_cleared got %b want 0", rs1_busy); end
        we = 1'b1; wr = 5'd12; wd = 32'h88;
        iss_valid = 1'b1; iss_rd = 5'd12;
        step();
        idle();
        #1;
        vectors++;
        if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b want 1", rs1_busy); end
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        idle();
        rr1 = 5'd0;
        #1;
        vectors++;
        if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_x0 got %b want 0", rs1_busy); end
    endtask

    task automatic test_flush();
        int addrs [5] = '{3, 4, 6, 8, 12};
        idle();
        iss_valid = 1'b1; iss_rd = 5'd3; step();
        iss_rd = 5'd4; step();
        iss_rd = 5'd6; step();
        idle();
        rr1 = 5'd3; rr2 = 5'd6;
        #1;
        vectors++;
        if ({rs1_busy, rs2_busy} !== 2'b11) begin
            errors++; $display("FAIL flush_pre got %b want 11", {rs1_busy, rs2_busy});
        end
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd8;
        step();
        idle();
        for (int i = 0; i < 5; i++) begin
            rr1 = 5'(addrs[i]);
            #1;
            vectors++;
            if (rs1_busy !== 1'b0) begin
                errors++; $display("FAIL flush_clear r%0d got %b want 0", addrs[i], rs1_busy);
            end
        end
        rd_en = 1'b1; rr1 = 5'd7; rr2 = 5'd12;
        step();
        vectors++;
        if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL flush_keep_r7 got %h want deadbeef", rd1); end
        vectors++;
        if (rd2 !== 32'h88) begin errors++; $display("FAIL flush_keep_r12 got %h want 88", rd2); end
    endtask

    task automatic test_async_reset();
        idle();
        we = 1'b1; wr = 5'd4; wd = 32'h55;
        step();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd4;
        rd_en = 1'b1; rr1 = 5'd4;
        step();
        idle();
        #1;
        vectors++;
        if (rd1 !== 32'h55 || rs1_busy !== 1'b1) begin
            errors++; $display("FAIL areset_setup got rd1=%h busy=%b want 55/1", rd1, rs1_busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rd1 !== 32'h0) begin errors++; $display("FAIL areset_rd1 got %h want 0", rd1); end
        vectors++;
        if (rs1_busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", rs1_busy); end
        #2;
        rst_n = 1'b1;
        rd_en = 1'b1; rr1 = 5'd4; rr2 = 5'd5;
        step();
        vectors++;
        if (rd1 !== 32'h0) begin errors++; $display("FAIL areset_r4 got %h want 0", rd1); end
        vectors++;
        if (rd2 !== 32'd4) begin errors++; $display("FAIL areset_preload got %h want 4", rd2); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
